// File: rtl/ifm_skew_reader_if.sv
// SRAM-side bus of the IFM skew reader: the reader is master, the SRAM wrapper is slave.
interface ifm_skew_reader_if #(
  parameter int SYS_HEIGHT = 9,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10
);
  logic [ADDR_W-1:0]            sram_A;
  logic                         sram_CS;
  logic                         sram_OE;
  logic [SYS_HEIGHT-1:0]        sram_WEB;
  logic [SYS_HEIGHT*DATA_W-1:0] sram_DO;

  modport master (output sram_A, output sram_CS, output sram_OE, output sram_WEB,
                  input  sram_DO);
  modport slave  (input  sram_A, input  sram_CS, input  sram_OE, input  sram_WEB,
                  output sram_DO);
endinterface

// File: rtl/ifm_skew_reader.sv
// Streams LENGTH IFM rows from SRAM (address wrap at DEPTH), absorbs the 1-cycle read
// latency with a skid register and skews lane i by i cycles for the systolic array.
module ifm_skew_reader #(
  parameter int SYS_HEIGHT = 9,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 912
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            base_addr,
  input  logic [ADDR_W-1:0]            length,
  input  logic                         hold,
  output logic                         busy,
  output logic                         done,
  ifm_skew_reader_if.master            sram,
  output logic [SYS_HEIGHT*DATA_W-1:0] lane_data,
  output logic [SYS_HEIGHT-1:0]        lane_valid
);
  localparam int W = SYS_HEIGHT * DATA_W;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   rem_q;
  logic                busy_q;
  logic                done_q;
  logic                pend_q;
  logic                skid_v_q;
  logic [W-1:0]        skid_q;

  logic                issue;
  logic                cap_v;
  logic [W-1:0]        cap_word;
  logic [SYS_HEIGHT-1:0] lane_nx;
  logic                empty_nx;

  assign issue    = (state_q == READ) && !hold;
  assign cap_v    = skid_v_q || pend_q;
  assign cap_word = skid_v_q ? skid_q : sram.sram_DO;

  // Pipeline is empty after this edge: nothing issued or in flight, and no lane keeps a valid.
  assign empty_nx = !issue && !pend_q && !skid_v_q && (lane_nx == '0);

  assign sram.sram_A   = addr_q;
  assign sram.sram_CS  = issue;
  assign sram.sram_OE  = issue;
  assign sram.sram_WEB = '1;
  assign busy          = busy_q;
  assign done          = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              addr_q  <= base_addr;
              rem_q   <= length;
              busy_q  <= 1'b1;
              state_q <= READ;
            end
          end
        end
        READ: begin
          if (!hold) begin
            addr_q <= (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
            rem_q  <= rem_q - 1'b1;
            if (rem_q == ADDR_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (empty_nx) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A word returning during hold is parked in the skid; no read issues while hold is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      pend_q <= issue;
      if (hold && pend_q) begin
        skid_q   <= sram.sram_DO;
        skid_v_q <= 1'b1;
      end else if (!hold) begin
        skid_v_q <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < SYS_HEIGHT; gi++) begin : g_lane
    logic [DATA_W-1:0] d_q [0:gi];
    logic [gi:0]       v_q;
    logic [gi:0]       low;
    logic              nx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int unsigned j = 0; j < gi + 1; j++) d_q[j] <= '0;
      end else if (!hold) begin
        d_q[0] <= cap_word[gi*DATA_W +: DATA_W];
        v_q[0] <= cap_v;
        for (int unsigned j = gi; j > 0; j--) begin
          d_q[j] <= d_q[j-1];
          v_q[j] <= v_q[j-1];
        end
      end
    end

    always_comb begin
      low     = v_q;
      low[gi] = 1'b0;
      nx      = hold ? (|v_q) : (|low);
    end

    assign lane_nx[gi]                    = nx;
    assign lane_valid[gi]                 = v_q[gi];
    assign lane_data[gi*DATA_W +: DATA_W] = v_q[gi] ? d_q[gi] : '0;
  end
endmodule

// File: tb/tb_ifm_skew_reader.sv
// Self-checking bench for ifm_skew_reader: SRAM model, address/lane scoreboards, timing table.
module tb_ifm_skew_reader;
  localparam int H  = 9;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int D  = 912;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   length;
  logic            hold;
  logic            busy;
  logic            done;
  logic [H*DW-1:0] lane_data;
  logic [H-1:0]    lane_valid;

  ifm_skew_reader_if #(.SYS_HEIGHT(H), .DATA_W(DW), .ADDR_W(AW)) sif ();

  ifm_skew_reader #(.SYS_HEIGHT(H), .DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .hold(hold), .busy(busy), .done(done), .sram(sif),
    .lane_data(lane_data), .lane_valid(lane_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [H*DW-1:0] mem [D];
  logic [95:0]     junk;

  // SRAM model: data for a read issued in cycle t is on DO during t+1; garbage otherwise.
  always @(posedge clk) begin
    junk = {$urandom(), $urandom(), $urandom()};
    if (sif.sram_CS && sif.sram_OE) sif.sram_DO <= mem[sif.sram_A];
    else                            sif.sram_DO <= junk[H*DW-1:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int base;
    int len;
    int hs;        // first hold cycle
    int hl;        // hold length (0 = none)
    int rs;        // cycle of a spurious start while busy (0 = none)
    int exp_done;  // cycle of the done pulse
    int exp_l0;    // first consumed cycle on lane 0 (0 = none)
    int exp_l8;    // first consumed cycle on lane 8
  } vec_t;

  int          addr_exp_q [$];
  logic [7:0]  lane_exp_q [H][$];

  // Caller leaves time at posedge+1 of the cycle that becomes cycle 0.
  task automatic run_vec(input string tag, input vec_t v);
    int issues, done_cyc, done_cnt, busy_err, zero_err, cs_hold, leftover, l8_cnt;
    int first [H];
    bit exp_busy;
    logic [7:0] exp_b;
    issues = 0; done_cyc = 0; done_cnt = 0; busy_err = 0; zero_err = 0;
    cs_hold = 0; leftover = 0; l8_cnt = 0;
    for (int i = 0; i < H; i++) begin first[i] = 0; lane_exp_q[i].delete(); end
    addr_exp_q.delete();
    for (int k = 0; k < v.len; k++) addr_exp_q.push_back((v.base + k) % D);

    start = 1'b1; base_addr = AW'(v.base); length = AW'(v.len); hold = 1'b0;
    for (int c = 1; c <= v.exp_done + 3; c++) begin
      @(posedge clk); #1;
      if (v.rs != 0 && c == v.rs) begin
        start = 1'b1; base_addr = AW'(3); length = AW'(7);
      end else begin
        start = 1'b0; base_addr = AW'(v.base); length = AW'(v.len);
      end
      hold = (v.hl > 0) && (c >= v.hs) && (c < v.hs + v.hl);
      @(negedge clk);
      if (sif.sram_CS) begin
        issues++;
        if (hold) cs_hold++;
        if (addr_exp_q.size() == 0) chk({tag, "_extra_issue"}, int'(sif.sram_A), -1);
        else chk({tag, "_addr"}, int'(sif.sram_A), addr_exp_q.pop_front());
        for (int i = 0; i < H; i++) lane_exp_q[i].push_back(mem[sif.sram_A][i*DW +: DW]);
      end
      for (int i = 0; i < H; i++) begin
        if (lane_valid[i] && !hold) begin
          if (first[i] == 0) first[i] = c;
          if (i == H - 1) l8_cnt++;
          if (lane_exp_q[i].size() == 0) chk({tag, "_lane_extra"}, i, -1);
          else begin
            exp_b = lane_exp_q[i].pop_front();
            chk({tag, "_lane_data"}, int'(lane_data[i*DW +: DW]), int'(exp_b));
          end
        end else if (!lane_valid[i] && lane_data[i*DW +: DW] != 8'd0) begin
          zero_err++;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      exp_busy = (v.len != 0) && (c < v.exp_done);
      if (busy != exp_busy) busy_err++;
    end
    for (int i = 0; i < H; i++) leftover += lane_exp_q[i].size();
    leftover += addr_exp_q.size();
    chk({tag, "_done_cycle"}, done_cyc, v.exp_done);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_issues"}, issues, v.len);
    chk({tag, "_leftover"}, leftover, 0);
    chk({tag, "_lane8_count"}, l8_cnt, v.len);
    chk({tag, "_lane0_first"}, first[0], v.exp_l0);
    chk({tag, "_lane8_first"}, first[H-1], v.exp_l8);
    chk({tag, "_busy_errs"}, busy_err, 0);
    chk({tag, "_zero_errs"}, zero_err, 0);
    chk({tag, "_cs_in_hold"}, cs_hold, 0);
    hold = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_cs"},    int'(sif.sram_CS), 0);
    chk({tag, "_oe"},    int'(sif.sram_OE), 0);
    chk({tag, "_addr"},  int'(sif.sram_A), 0);
    chk({tag, "_valid"}, int'(lane_valid), 0);
    chk({tag, "_ldata"}, int'(lane_data != '0), 0);
  endtask

  vec_t vecs [7];
  int   late_done;

  initial begin
    logic [95:0] r;
    for (int i = 0; i < D; i++) begin
      r = {$urandom(), $urandom(), $urandom()};
      mem[i] = r[H*DW-1:0];
    end
    //          base len hs hl rs done l0 l8
    vecs[0] = '{0,   3,  0, 0, 0, 14, 3, 11};
    vecs[1] = '{910, 4,  0, 0, 0, 15, 3, 11};
    vecs[2] = '{0,   3,  2, 2, 0, 16, 5, 13};
    vecs[3] = '{5,   0,  0, 0, 0, 1,  0, 0};
    vecs[4] = '{100, 5,  0, 0, 3, 16, 3, 11};
    vecs[5] = '{900, 20, 10, 3, 0, 34, 3, 14};
    vecs[6] = '{50,  2,  8, 3, 0, 16, 3, 14};

    rst_n = 1'b0; start = 1'b0; hold = 1'b0; base_addr = '0; length = '0;
    #1;
    chk_quiet("reset");
    chk("web_ones", int'(sif.sram_WEB), (1 << H) - 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 7; n++) run_vec($sformatf("vec%0d", n), vecs[n]);

    // Reset in the middle of a read burst: everything clears at once and no done follows.
    start = 1'b1; base_addr = AW'(200); length = AW'(6);
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_busy_before", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("midrst");
    late_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) late_done++;
    end
    chk("midrst_no_done", late_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) late_done++;
    end
    chk("midrst_no_done_after", late_done, 0);
    @(posedge clk); #1;
    run_vec("post_rst", '{300, 3, 0, 0, 0, 14, 3, 11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=%0d expected=%0d", 1, 0);
    $fatal(1, "bench timeout");
  end
endmodule
